// File: rtl/operand_sequencer.sv
// operand_sequencer: walks one instruction through IP write, operand fetch
// (with optional pointer dereference), ALU, destination write, post-modify
// writebacks and finish, advancing one step per step_valid && done.
// Optional build macro: OPSEQ_FWD_EN -- when defined, fill flags FETCH steps
// that can be served by forwarding; when undefined, fill is tied low.
module operand_sequencer #(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int IP_REG  = 15,
    localparam int NSLOT  = NUM_SRC + 2,
    localparam int SLOT_W = $clog2(NSLOT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NSLOT*REG_W-1:0] reg_num,
    input  logic [NSLOT-1:0]       is_ptr,
    input  logic [2*NSLOT-1:0]     mod_flags,
    input  logic [DATA_W-1:0]      cond,
    input  logic                   done,
    output logic [2:0]             step,
    output logic [SLOT_W-1:0]      slot,
    output logic                   fill,
    output logic                   step_valid,
    output logic                   busy,
    output logic                   ip_save,
    output logic                   skipped,
    output logic                   finish
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_IP_WR     = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_FETCH_PTR = 3'd3;
    localparam logic [2:0] S_ALU       = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_WRITE_PTR = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    localparam int                DST      = NSLOT - 1;
    localparam logic [SLOT_W-1:0] DST_SLOT = SLOT_W'(DST);
    localparam logic [SLOT_W-1:0] SLOT0    = '0;
    localparam logic [REG_W-1:0]  IP_R     = REG_W'(IP_REG);
    localparam int                NXT_W    = 3 + SLOT_W;

    logic [2:0]             stepQ;
    logic [SLOT_W-1:0]      slotQ;
    logic [NXT_W-1:0]       nxt;
    logic [NSLOT*REG_W-1:0] regQ, regE;
    logic [NSLOT-1:0]       ptrQ, ptrE;
    logic [2*NSLOT-1:0]     flagsQ, flagsE;
    logic                   condTrueQ, skippedQ, ipSaveQ;
    logic [REG_W-1:0]       rs [NSLOT];
    logic [NSLOT-1:0]       fetchMask, wbMaskT, wbMaskF, wbMaskC, laterHit;
    logic                   dstCand, dstPtr, ipHit, ipSaveE, idle, condSample;

    // Lowest set bit of m at or above 'from'; NSLOT when none.
    function automatic int firstFrom(input logic [NSLOT-1:0] m, input int from);
        int r = NSLOT;
        for (int i = NSLOT - 1; i >= 0; i--)
            if (m[i] && i >= from) r = i;
        return r;
    endfunction

    // Next writeback step, or FINISH when no writeback remains.
    function automatic logic [NXT_W-1:0] wbGo(input int nw);
        if (nw < NSLOT) return {S_WRITE, SLOT_W'(nw)};
        return {S_FINISH, SLOT0};
    endfunction

    // Next fetch step, then the dst pointer fetch, then ALU.
    function automatic logic [NXT_W-1:0] fetchGo(input int nf, input logic dp);
        if (nf < NSLOT) return {S_FETCH, SLOT_W'(nf)};
        if (dp) return {S_FETCH, DST_SLOT};
        return {S_ALU, SLOT0};
    endfunction

    // In IDLE the decision for the first step must come straight from the inputs.
    assign idle    = (stepQ == S_IDLE);
    assign regE    = idle ? reg_num   : regQ;
    assign ptrE    = idle ? is_ptr    : ptrQ;
    assign flagsE  = idle ? mod_flags : flagsQ;
    assign dstPtr  = ptrE[DST];
    assign ipSaveE = !ipHit;
    assign wbMaskC = condTrueQ ? wbMaskT : wbMaskF;

    // Unpack register numbers per slot.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) rs[k] = regE[k*REG_W +: REG_W];
    end

    // Fetch set, IP hazard and writeback masks; highest writer of a register wins.
    always_comb begin
        fetchMask = '0;
        wbMaskF   = '0;
        wbMaskT   = '0;
        laterHit  = '0;
        dstCand   = flagsE[2*DST +: 2] != 2'b11;
        ipHit     = dstCand && (rs[DST] == IP_R);
        for (int k = 0; k <= NUM_SRC; k++) begin
            fetchMask[k] = flagsE[2*k +: 2] != 2'b11;
            if (^flagsE[2*k +: 2] && rs[k] == IP_R) ipHit = 1'b1;
            for (int j = k + 1; j <= NUM_SRC; j++)
                if (^flagsE[2*j +: 2] && rs[j] == rs[k]) laterHit[k] = 1'b1;
            wbMaskF[k] = ^flagsE[2*k +: 2] && !laterHit[k];
            wbMaskT[k] = wbMaskF[k] && !(dstCand && rs[DST] == rs[k]);
        end
    end

    // State register: current step and addressed slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            stepQ <= S_IDLE;
            slotQ <= '0;
        end else begin
            {stepQ, slotQ} <= nxt;
        end
    end

    // Next-state: pick the following step whenever the current one completes.
    always_comb begin
        nxt        = {stepQ, slotQ};
        condSample = 1'b0;
        case (stepQ)
            S_IDLE: begin
                if (start)
                    nxt = ipSaveE ? {S_IP_WR, SLOT0} : fetchGo(firstFrom(fetchMask, 0), dstPtr);
            end
            S_FINISH: nxt = {S_IDLE, SLOT0};
            default: begin
                if (done) begin
                    case (stepQ)
                        S_IP_WR: nxt = fetchGo(firstFrom(fetchMask, 0), dstPtr);
                        S_FETCH, S_FETCH_PTR: begin
                            if (slotQ == DST_SLOT)
                                nxt = {S_ALU, SLOT0};
                            else if (stepQ == S_FETCH && ptrE[slotQ])
                                nxt = {S_FETCH_PTR, slotQ};
                            else if (slotQ == SLOT0 && cond == '0) begin
                                // false condition: drop remaining fetches and ALU
                                condSample = 1'b1;
                                nxt        = wbGo(firstFrom(wbMaskF, 0));
                            end else begin
                                condSample = (slotQ == SLOT0);
                                nxt        = fetchGo(firstFrom(fetchMask, int'(slotQ) + 1), dstPtr);
                            end
                        end
                        S_ALU: begin
                            if (dstCand && condTrueQ)
                                nxt = {dstPtr ? S_WRITE_PTR : S_WRITE, DST_SLOT};
                            else
                                nxt = wbGo(firstFrom(wbMaskC, 0));
                        end
                        S_WRITE, S_WRITE_PTR: begin
                            if (slotQ == DST_SLOT)
                                nxt = wbGo(firstFrom(wbMaskC, 0));
                            else
                                nxt = wbGo(firstFrom(wbMaskC, int'(slotQ) + 1));
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Instruction latch plus condition / skip / IP-save tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            regQ      <= '0;
            ptrQ      <= '0;
            flagsQ    <= '1;
            condTrueQ <= 1'b1;
            skippedQ  <= 1'b0;
            ipSaveQ   <= 1'b0;
        end else if (idle && start) begin
            regQ      <= reg_num;
            ptrQ      <= is_ptr;
            flagsQ    <= mod_flags;
            condTrueQ <= 1'b1;
            skippedQ  <= 1'b0;
            ipSaveQ   <= ipSaveE;
        end else if (stepQ == S_FINISH) begin
            skippedQ <= 1'b0;
            ipSaveQ  <= 1'b0;
        end else if (condSample) begin
            condTrueQ <= (cond != '0);
            skippedQ  <= (cond == '0);
        end
    end

`ifdef OPSEQ_FWD_EN
    logic fwdHit;

    // Forwardable fetch: IP register, or same register as an earlier fetched slot.
    always_comb begin
        fwdHit = (rs[slotQ] == IP_R);
        for (int j = 0; j <= NUM_SRC; j++)
            if (j < int'(slotQ) && fetchMask[j] && rs[j] == rs[slotQ]) fwdHit = 1'b1;
    end
`endif

    // Outputs decoded from the current step and tracking flags.
    always_comb begin
        step       = stepQ;
        slot       = slotQ;
        busy       = (stepQ != S_IDLE);
        step_valid = (stepQ != S_IDLE) && (stepQ != S_FINISH);
        finish     = (stepQ == S_FINISH);
        ip_save    = ipSaveQ;
        skipped    = skippedQ;
`ifdef OPSEQ_FWD_EN
        fill = (stepQ == S_FETCH) && fwdHit;
`else
        fill = 1'b0;
`endif
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer (NUM_SRC=2): step traces are encoded as
// step*100 + slot*10 + fill and compared to hand-derived sequences.
module tb_operand_sequencer;
    logic        clk, rst, start, done;
    logic [15:0] reg_num;
    logic [3:0]  is_ptr;
    logic [7:0]  mod_flags;
    logic [31:0] cond;
    logic [2:0]  step;
    logic [1:0]  slot;
    logic        fill, step_valid, busy, ip_save, skipped, finish;

    int vecs = 0;
    int errs = 0;
`ifdef OPSEQ_FWD_EN
    int F = 1;
`else
    int F = 0;
`endif

    typedef struct {
        logic [2:0] st;
        logic [1:0] sl;
        logic fl, iv, sk, bz, sv, fn;
    } smp_t;
    smp_t tr[$];

    operand_sequencer #(.NUM_SRC(2), .REG_W(4), .DATA_W(32), .IP_REG(15)) dut (
        .clk(clk), .rst(rst), .start(start), .reg_num(reg_num), .is_ptr(is_ptr),
        .mod_flags(mod_flags), .cond(cond), .done(done), .step(step), .slot(slot),
        .fill(fill), .step_valid(step_valid), .busy(busy), .ip_save(ip_save),
        .skipped(skipped), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int enc(input smp_t s);
        return int'(s.st) * 100 + int'(s.sl) * 10 + int'(s.fl);
    endfunction

    task automatic rec();
        smp_t s;
        s.st = step; s.sl = slot; s.fl = fill; s.iv = ip_save;
        s.sk = skipped; s.bz = busy; s.sv = step_valid; s.fn = finish;
        tr.push_back(s);
    endtask

    // Start one instruction with done high, scramble inputs after latching, record
    // every cycle through FINISH plus the following IDLE cycle.
    task automatic run_instr(input logic [15:0] rn, input logic [3:0] pt, input logic [7:0] fl,
                             input logic [31:0] cv, input int holdIdx, input int holdN);
        tr.delete();
        reg_num = rn; is_ptr = pt; mod_flags = fl; cond = cv; start = 1'b1; done = 1'b1;
        tick();
        start = 1'b0;
        reg_num = 16'($urandom); is_ptr = 4'($urandom); mod_flags = 8'($urandom);
        for (int c = 0; c < 40; c++) begin
            rec();
            if (tr.size() - 1 == holdIdx) begin
                done = 1'b0;
                repeat (holdN) begin tick(); rec(); end
                done = 1'b1;
            end
            if (step == 3'd7) begin tick(); rec(); break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; done = 1'b0; reg_num = '0; is_ptr = '0; mod_flags = '0; cond = '0;
        tick(); tick();
        vecs++; if (step !== 3'd0) begin errs++; $display("FAIL reset_step got %0d want 0", step); end
        vecs++; if (slot !== 2'd0) begin errs++; $display("FAIL reset_slot got %0d want 0", slot); end
        vecs++; if ({fill, step_valid, busy, ip_save, skipped, finish} !== 6'b0) begin
            errs++; $display("FAIL reset_flags got %b want 000000", {fill, step_valid, busy, ip_save, skipped, finish});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int exp[$];
        int nfin = 0;
        exp = '{100, 210, 220, 400, 530, 700, 0};
        run_instr(16'h3210, 4'b0000, 8'b00_00_00_11, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL basic_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL basic_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        foreach (tr[i]) nfin += int'(tr[i].fn);
        vecs++; if (nfin != 1) begin errs++; $display("FAIL basic_finish_count got %0d want 1", nfin); end
        vecs++; if (tr[0].iv !== 1'b1 || tr[0].bz !== 1'b1 || tr[0].sv !== 1'b1) begin
            errs++; $display("FAIL basic_first_flags got iv=%b bz=%b sv=%b want 1 1 1", tr[0].iv, tr[0].bz, tr[0].sv);
        end
        vecs++; if (tr[5].bz !== 1'b1 || tr[5].sv !== 1'b0) begin
            errs++; $display("FAIL basic_finish_flags got bz=%b sv=%b want 1 0", tr[5].bz, tr[5].sv);
        end
        vecs++; if (tr[6].bz !== 1'b0) begin errs++; $display("FAIL basic_idle_busy got %b want 0", tr[6].bz); end
    endtask

    task automatic test_cond_false();
        int exp[$];
        exp = '{100, 200, 510, 700, 0};
        run_instr(16'h6054, 4'b0000, 8'b00_11_01_00, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL condf_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL condf_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        if (tr.size() == exp.size()) begin
            vecs++; if ({tr[0].sk, tr[2].sk, tr[3].sk, tr[4].sk} !== 4'b0110) begin
                errs++; $display("FAIL condf_skipped got %b want 0110", {tr[0].sk, tr[2].sk, tr[3].sk, tr[4].sk});
            end
        end
    endtask

    task automatic test_cond_true();
        int exp[$];
        exp = '{100, 200, 210, 400, 530, 510, 700, 0};
        run_instr(16'h6054, 4'b0000, 8'b00_11_01_00, 32'd5, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL condt_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL condt_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        vecs++; if (tr[4].sk !== 1'b0) begin errs++; $display("FAIL condt_skipped got %b want 0", tr[4].sk); end
    endtask

    task automatic test_ip_dst_fill();
        int exp[$];
        exp = '{200, 210 + F, 220 + F, 400, 530, 700, 0};
        run_instr(16'hF4F4, 4'b0000, 8'b00_00_00_00, 32'd1, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL ipdst_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL ipdst_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        vecs++; if (tr[0].iv !== 1'b0) begin errs++; $display("FAIL ipdst_ip_save got %b want 0", tr[0].iv); end
    endtask

    task automatic test_suppress();
        int exp[$];
        exp = '{100, 210, 220 + F, 400, 530, 520, 700, 0};
        run_instr(16'h7220, 4'b0000, 8'b00_10_01_11, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL supp_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL supp_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
    endtask

    task automatic test_dst_suppress();
        int exp[$];
        exp = '{100, 210, 400, 530, 700, 0};
        run_instr(16'h2020, 4'b0000, 8'b00_11_01_11, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL dsupp_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL dsupp_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
    endtask

    task automatic test_ptr_dst_hold();
        int exp[$];
        exp = '{100, 210, 210, 210, 210, 210, 210, 230, 400, 630, 700, 0};
        run_instr(16'h9010, 4'b1000, 8'b00_11_00_11, 32'd0, 1, 5);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL ptrdst_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL ptrdst_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        for (int i = 1; i <= 6 && i < tr.size(); i++) begin
            vecs++; if (tr[i].sv !== 1'b1) begin errs++; $display("FAIL ptrdst_hold_valid[%0d] got %b want 1", i, tr[i].sv); end
        end
    endtask

    task automatic test_ptr_cond();
        int exp[$];
        exp = '{100, 200, 300, 510, 700, 0};
        run_instr(16'h6054, 4'b0001, 8'b00_11_01_00, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL ptrcond_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL ptrcond_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
        if (tr.size() == exp.size()) begin
            vecs++; if ({tr[2].sk, tr[3].sk} !== 2'b01) begin
                errs++; $display("FAIL ptrcond_skipped got %b want 01", {tr[2].sk, tr[3].sk});
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp[$];
        reg_num = 16'h3210; is_ptr = '0; mod_flags = 8'b00_00_00_11; cond = '0; start = 1'b1; done = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && step != 3'd4; c++) tick();
        vecs++; if (step !== 3'd4) begin errs++; $display("FAIL rstmid_reach_alu got %0d want 4", step); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (step !== 3'd0 || busy !== 1'b0) begin errs++; $display("FAIL rstmid_idle got step=%0d busy=%b want 0 0", step, busy); end
        vecs++; if ({step_valid, ip_save, finish, slot} !== 5'b0) begin
            errs++; $display("FAIL rstmid_flags got %b want 00000", {step_valid, ip_save, finish, slot});
        end
        tick();
        vecs++; if (step !== 3'd0) begin errs++; $display("FAIL rstmid_stays_idle got %0d want 0", step); end
        exp = '{100, 210, 220, 400, 530, 700, 0};
        run_instr(16'h3210, 4'b0000, 8'b00_00_00_11, 32'd0, -1, 0);
        vecs++; if (tr.size() != exp.size()) begin errs++; $display("FAIL rstmid_len got %0d want %0d", tr.size(), exp.size()); end
        foreach (exp[i]) if (i < tr.size()) begin
            vecs++; if (enc(tr[i]) !== exp[i]) begin errs++; $display("FAIL rstmid_step[%0d] got %0d want %0d", i, enc(tr[i]), exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cond_false();
        test_cond_true();
        test_ip_dst_fill();
        test_suppress();
        test_dst_suppress();
        test_ptr_dst_hold();
        test_ptr_cond();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
